// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the DE-side hazard controller.
// Holds the state encoding and the AGEX/WB-to-DE field layouts.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned NREGS        = 32;
    localparam int unsigned REGNOBITS    = 5;
    localparam int unsigned MAX_INFLIGHT = 3;
    localparam int unsigned CNTBITS      = 2;
    localparam int unsigned PERFBITS     = 32;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_DRAIN = 1'b1
    } hz_state_e;

    localparam int unsigned AGEX_TO_DE_W = 1;
    localparam int unsigned WB_TO_DE_W   = REGNOBITS + 2;

    typedef struct packed {
        logic br_mispred;
    } from_agex_to_de_t;

    typedef struct packed {
        logic                 valid;
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
    } from_wb_to_de_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// Per-register in-flight write counters with three read ports.
// x0 has no storage: it reads as zero and issues/retires to it are dropped.
module hz_scoreboard #(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned REGNOBITS = 5,
    parameter int unsigned CNTBITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_en,
    input  logic [REGNOBITS-1:0] inc_reg,
    input  logic                 dec_en,
    input  logic [REGNOBITS-1:0] dec_reg,
    input  logic [REGNOBITS-1:0] rd_a,
    input  logic [REGNOBITS-1:0] rd_b,
    input  logic [REGNOBITS-1:0] rd_c,
    output logic [CNTBITS-1:0]   cnt_a,
    output logic [CNTBITS-1:0]   cnt_b,
    output logic [CNTBITS-1:0]   cnt_c,
    output logic                 sb_empty,
    output logic                 sb_err
);
    import pipe_hazard_ctrl_pkg::*;

    logic [CNTBITS-1:0] cnt_q [1:NREGS-1];
    logic [NREGS-1:1]   inc_vec;
    logic [NREGS-1:1]   dec_vec;
    logic               dec_zero;

    always_comb begin
        cnt_a    = '0;
        cnt_b    = '0;
        cnt_c    = '0;
        sb_empty = 1'b1;
        dec_zero = 1'b0;
        inc_vec  = '0;
        dec_vec  = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc_vec[r] = inc_en && (inc_reg == REGNOBITS'(r));
            dec_vec[r] = dec_en && (dec_reg == REGNOBITS'(r));
            if (rd_a == REGNOBITS'(r)) cnt_a = cnt_q[r];
            if (rd_b == REGNOBITS'(r)) cnt_b = cnt_q[r];
            if (rd_c == REGNOBITS'(r)) cnt_c = cnt_q[r];
            if (cnt_q[r] != '0) sb_empty = 1'b0;
            // A matching issue in the same cycle covers the retire, so no underflow
            if (dec_vec[r] && !inc_vec[r] && cnt_q[r] == '0) dec_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 1; r < NREGS; r++) cnt_q[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && cnt_q[r] != '0)
                    cnt_q[r] <= cnt_q[r] - 1'b1;
            end
            if (dec_zero) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// DE-side hazard controller: RAW/WAW stalls, fence drain and mispredict flush.
// Stall/issue/flush are same-cycle combinational; the FSM and perf counter are registered.
module pipe_hazard_ctrl #(
    parameter int unsigned NREGS        = pipe_hazard_ctrl_pkg::NREGS,
    parameter int unsigned REGNOBITS    = pipe_hazard_ctrl_pkg::REGNOBITS,
    parameter int unsigned MAX_INFLIGHT = pipe_hazard_ctrl_pkg::MAX_INFLIGHT,
    parameter int unsigned CNTBITS      = pipe_hazard_ctrl_pkg::CNTBITS,
    parameter int unsigned PERFBITS     = pipe_hazard_ctrl_pkg::PERFBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    input  logic                 de_use_rs1,
    input  logic                 de_use_rs2,
    input  logic [REGNOBITS-1:0] de_rs1,
    input  logic [REGNOBITS-1:0] de_rs2,
    input  logic                 de_wr_reg,
    input  logic [REGNOBITS-1:0] de_wregno,
    input  logic                 de_is_fence,
    input  logic                 agex_br_mispred,
    input  logic                 wb_valid,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    output logic                 stall_de,
    output logic                 de_issue,
    output logic                 flush_de,
    output logic                 flush_fe,
    output logic                 sb_empty,
    output logic                 sb_err,
    output logic [PERFBITS-1:0]  stall_cycles
);
    import pipe_hazard_ctrl_pkg::*;

    hz_state_e          state_q;
    from_agex_to_de_t   agex_in;
    from_wb_to_de_t     wb_in;
    logic [CNTBITS-1:0] rs1_cnt, rs2_cnt, wr_cnt;
    logic               raw, waw_full, mispred, issue_wr;

    assign agex_in = from_agex_to_de_t'(agex_br_mispred);
    assign wb_in   = {wb_valid, wb_wr_reg, wb_wregno};

    hz_scoreboard #(
        .NREGS     (NREGS),
        .REGNOBITS (REGNOBITS),
        .CNTBITS   (CNTBITS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (issue_wr),
        .inc_reg  (de_wregno),
        .dec_en   (wb_in.valid && wb_in.wr_reg),
        .dec_reg  (wb_in.wregno),
        .rd_a     (de_rs1),
        .rd_b     (de_rs2),
        .rd_c     (de_wregno),
        .cnt_a    (rs1_cnt),
        .cnt_b    (rs2_cnt),
        .cnt_c    (wr_cnt),
        .sb_empty (sb_empty),
        .sb_err   (sb_err)
    );

    always_comb begin
        mispred  = agex_in.br_mispred;
        raw      = (de_use_rs1 && de_rs1 != '0 && rs1_cnt != '0) ||
                   (de_use_rs2 && de_rs2 != '0 && rs2_cnt != '0);
        waw_full = de_wr_reg && de_wregno != '0 && wr_cnt == CNTBITS'(MAX_INFLIGHT);
        stall_de = 1'b0;
        de_issue = 1'b0;
        flush_de = 1'b0;
        flush_fe = 1'b0;
        // Handshakes are held quiet while reset is asserted, whatever DE presents
        if (!reset) begin
            if (state_q == HZ_DRAIN)
                stall_de = !sb_empty && !mispred;
            else
                stall_de = de_valid && (raw || waw_full || (de_is_fence && !sb_empty)) && !mispred;
            de_issue = de_valid && !stall_de && !mispred;
            flush_de = mispred;
            flush_fe = mispred;
        end
        issue_wr = de_issue && de_wr_reg && de_wregno != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HZ_RUN;
            stall_cycles <= '0;
        end else begin
            case (state_q)
                HZ_RUN:
                    if (de_valid && de_is_fence && !sb_empty && !mispred) state_q <= HZ_DRAIN;
                HZ_DRAIN:
                    if (mispred || sb_empty) state_q <= HZ_RUN;
                default:
                    state_q <= HZ_RUN;
            endcase
            if (stall_de && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with an expected-value queue,
// plus hand sequences for reset behaviour.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid, de_use_rs1, de_use_rs2, de_wr_reg, de_is_fence;
    logic [4:0]  de_rs1, de_rs2, de_wregno, wb_wregno;
    logic        agex_br_mispred, wb_valid, wb_wr_reg;
    logic        stall_de, de_issue, flush_de, flush_fe, sb_empty, sb_err;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic        st, is, fd, ff, em, er;
        logic [31:0] sc;
    } exp_t;

    typedef struct {
        string      name;
        logic       dv, u1, u2, wr, fn, mp, wbv;
        logic [4:0] rs1, rs2, wreg, wbreg;
        exp_t       exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .de_valid        (de_valid),
        .de_use_rs1      (de_use_rs1),
        .de_use_rs2      (de_use_rs2),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_wr_reg       (de_wr_reg),
        .de_wregno       (de_wregno),
        .de_is_fence     (de_is_fence),
        .agex_br_mispred (agex_br_mispred),
        .wb_valid        (wb_valid),
        .wb_wr_reg       (wb_wr_reg),
        .wb_wregno       (wb_wregno),
        .stall_de        (stall_de),
        .de_issue        (de_issue),
        .flush_de        (flush_de),
        .flush_fe        (flush_fe),
        .sb_empty        (sb_empty),
        .sb_err          (sb_err),
        .stall_cycles    (stall_cycles)
    );

    function automatic exp_t mkexp(logic st, logic is, logic fl, logic em, logic er, int sc);
        exp_t e;
        e = '{st: st, is: is, fd: fl, ff: fl, em: em, er: er, sc: 32'(sc)};
        return e;
    endfunction

    function automatic vec_t mk(string nm, logic dv, logic u1, logic [4:0] rs1, logic u2, logic [4:0] rs2,
                                logic wr, logic [4:0] wreg, logic fn, logic mp, logic wbv, logic [4:0] wbreg,
                                logic st, logic is, logic fl, logic em, logic er, int sc);
        vec_t v;
        v.name = nm; v.dv = dv; v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
        v.wr = wr; v.wreg = wreg; v.fn = fn; v.mp = mp; v.wbv = wbv; v.wbreg = wbreg;
        v.exp = mkexp(st, is, fl, em, er, sc);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        de_valid = v.dv; de_use_rs1 = v.u1; de_rs1 = v.rs1; de_use_rs2 = v.u2; de_rs2 = v.rs2;
        de_wr_reg = v.wr; de_wregno = v.wreg; de_is_fence = v.fn; agex_br_mispred = v.mp;
        wb_valid = v.wbv; wb_wr_reg = v.wbv; wb_wregno = v.wbreg;
    endtask

    task automatic compare(input string nm);
        exp_t got, e;
        got = '{st: stall_de, is: de_issue, fd: flush_de, ff: flush_fe, em: sb_empty, er: sb_err, sc: stall_cycles};
        e = sbq.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0b is=%0b fd=%0b ff=%0b em=%0b er=%0b sc=%0d, want st=%0b is=%0b fd=%0b ff=%0b em=%0b er=%0b sc=%0d",
                     nm, got.st, got.is, got.fd, got.ff, got.em, got.er, got.sc,
                     e.st, e.is, e.fd, e.ff, e.em, e.er, e.sc);
        end
    endtask

    // Drive at posedge+1, check before the next edge, leave at posedge+1
    task automatic step(input vec_t v);
        drive(v);
        sbq.push_back(v.exp);
        @(negedge clk);
        compare(v.name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          name            dv u1 rs1 u2 rs2 wr wreg fn mp wbv wbreg  st is fl em er sc
        tbl.push_back(mk("idle",        0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("raw_prod",    1, 0, 0,  0, 0,  1, 5,   0, 0, 0, 0,    0, 1, 0, 1, 0, 0));
        tbl.push_back(mk("raw_stall1",  1, 1, 5,  0, 0,  1, 6,   0, 0, 0, 0,    1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("raw_stall2",  1, 1, 5,  0, 0,  1, 6,   0, 0, 0, 0,    1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("raw_stall_wb",1, 1, 5,  0, 0,  1, 6,   0, 0, 1, 5,    1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("raw_issue",   1, 1, 5,  0, 0,  1, 6,   0, 0, 0, 0,    0, 1, 0, 1, 0, 3));
        tbl.push_back(mk("ret_x6",      0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 6,    0, 0, 0, 0, 0, 3));
        tbl.push_back(mk("wr_x0",       1, 0, 0,  0, 0,  1, 0,   0, 0, 0, 0,    0, 1, 0, 1, 0, 3));
        tbl.push_back(mk("rd_x0",       1, 1, 0,  1, 0,  0, 0,   0, 0, 0, 0,    0, 1, 0, 1, 0, 3));
        tbl.push_back(mk("waw1",        1, 0, 0,  0, 0,  1, 7,   0, 0, 0, 0,    0, 1, 0, 1, 0, 3));
        tbl.push_back(mk("waw2",        1, 0, 0,  0, 0,  1, 7,   0, 0, 0, 0,    0, 1, 0, 0, 0, 3));
        tbl.push_back(mk("waw3",        1, 0, 0,  0, 0,  1, 7,   0, 0, 0, 0,    0, 1, 0, 0, 0, 3));
        tbl.push_back(mk("waw_full",    1, 0, 0,  0, 0,  1, 7,   0, 0, 0, 0,    1, 0, 0, 0, 0, 3));
        tbl.push_back(mk("waw_full_wb", 1, 0, 0,  0, 0,  1, 7,   0, 0, 1, 7,    1, 0, 0, 0, 0, 4));
        tbl.push_back(mk("waw_incdec",  1, 0, 0,  0, 0,  1, 7,   0, 0, 1, 7,    0, 1, 0, 0, 0, 5));
        tbl.push_back(mk("ret_x7a",     0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 7,    0, 0, 0, 0, 0, 5));
        tbl.push_back(mk("ret_x7b",     0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 7,    0, 0, 0, 0, 0, 5));
        tbl.push_back(mk("waw_empty",   0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 0, 5));
        tbl.push_back(mk("mp_prod",     1, 0, 0,  0, 0,  1, 8,   0, 0, 0, 0,    0, 1, 0, 1, 0, 5));
        tbl.push_back(mk("mp_flush",    1, 1, 8,  0, 0,  1, 9,   0, 1, 0, 0,    0, 0, 1, 0, 0, 5));
        tbl.push_back(mk("mp_after",    1, 1, 8,  0, 0,  1, 9,   0, 0, 0, 0,    1, 0, 0, 0, 0, 5));
        tbl.push_back(mk("ret_x8",      0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 8,    0, 0, 0, 0, 0, 6));
        tbl.push_back(mk("fn_w3",       1, 0, 0,  0, 0,  1, 3,   0, 0, 0, 0,    0, 1, 0, 1, 0, 6));
        tbl.push_back(mk("fn_w4",       1, 0, 0,  0, 0,  1, 4,   0, 0, 0, 0,    0, 1, 0, 0, 0, 6));
        tbl.push_back(mk("fn_enter",    1, 0, 0,  0, 0,  0, 0,   1, 0, 0, 0,    1, 0, 0, 0, 0, 6));
        tbl.push_back(mk("fn_drain_wb3",1, 0, 0,  0, 0,  0, 0,   1, 0, 1, 3,    1, 0, 0, 0, 0, 7));
        tbl.push_back(mk("fn_drain_wb4",1, 0, 0,  0, 0,  0, 0,   1, 0, 1, 4,    1, 0, 0, 0, 0, 8));
        tbl.push_back(mk("fn_issue",    1, 0, 0,  0, 0,  0, 0,   1, 0, 0, 0,    0, 1, 0, 1, 0, 9));
        tbl.push_back(mk("run_w10",     1, 0, 0,  0, 0,  1, 10,  0, 0, 0, 0,    0, 1, 0, 1, 0, 9));
        tbl.push_back(mk("run_chk",     0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 10,   0, 0, 0, 0, 0, 9));
        tbl.push_back(mk("err_set",     0, 0, 0,  0, 0,  0, 0,   0, 0, 1, 9,    0, 0, 0, 1, 0, 9));
        tbl.push_back(mk("err_sticky",  0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 1, 9));
        tbl.push_back(mk("dr_w11",      1, 0, 0,  0, 0,  1, 11,  0, 0, 0, 0,    0, 1, 0, 1, 1, 9));
        tbl.push_back(mk("dr_enter",    1, 0, 0,  0, 0,  0, 0,   1, 0, 0, 0,    1, 0, 0, 0, 1, 9));
        tbl.push_back(mk("dr_squash",   1, 0, 0,  0, 0,  0, 0,   1, 1, 0, 0,    0, 0, 1, 0, 1, 10));
        tbl.push_back(mk("dr_run",      0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1, 10));
        tbl.push_back(mk("dr_enter2",   1, 0, 0,  0, 0,  0, 0,   1, 0, 0, 0,    1, 0, 0, 0, 1, 10));

        // Reset with a valid mispredicting DE: all handshakes must stay low
        reset = 1'b1;
        drive(mk("rst_in", 1, 1, 3, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        @(posedge clk);
        #2;
        sbq.push_back(mkexp(0, 0, 0, 1, 0, 0));
        compare("reset_state");
        @(negedge clk);
        reset = 1'b0;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // Still in DRAIN with x11 outstanding; pulse reset asynchronously mid-cycle
        drive(mk("dr_hold", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        sbq.push_back(mkexp(1, 0, 0, 0, 1, 11));
        compare("drain_before_rst");
        #1;
        agex_br_mispred = 1'b1;
        reset = 1'b1;
        #1;
        sbq.push_back(mkexp(0, 0, 0, 1, 0, 0));
        compare("async_rst_mid");
        @(posedge clk);
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        step(mk("post_rst_ret11", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 0));
        step(mk("post_rst_err",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary, want completion");
        $fatal(1, "timeout");
    end

endmodule
